// File: rtl/gpmc_pkg.sv
// Shared GPMC definitions: bus width, master state encoding, strobe idle levels.
// No logic; constants and a counter-width helper only.
// No flow control of its own.
package gpmc_pkg;

    localparam int GPMC_AD_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_TURN = 2'd3
    } gpmc_state_t;

    localparam logic CSN_IDLE   = 1'b1;
    localparam logic ADVN_IDLE  = 1'b1;
    localparam logic WEIN_IDLE  = 1'b1;
    localparam logic OEN_IDLE   = 1'b1;
    localparam logic AD_OE_IDLE = 1'b0;

    // Bits needed to hold wait counts 0..max_wait (at least one bit).
    function automatic int cnt_width(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/gpmc_sync_master_if.sv
// Request/response port plus GPMC pad-side signals of the synchronous GPMC master.
// Pure wiring, no latency.
// Request side is valid/ready; the GPMC side has no backpressure.
interface gpmc_sync_master_if
    import gpmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
);
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_we;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [GPMC_AD_WIDTH-1:0] req_wdata;
    logic                     rsp_valid;
    logic [GPMC_AD_WIDTH-1:0] rsp_rdata;
    logic                     gpmc_clk;
    logic                     gpmc_csn;
    logic                     gpmc_advn;
    logic                     gpmc_wein;
    logic                     gpmc_oen;
    logic [GPMC_AD_WIDTH-1:0] gpmc_ad_out;
    logic                     gpmc_ad_oe;
    logic [GPMC_AD_WIDTH-1:0] gpmc_ad_in;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, gpmc_ad_in,
        output req_ready, rsp_valid, rsp_rdata, gpmc_clk, gpmc_csn, gpmc_advn,
               gpmc_wein, gpmc_oen, gpmc_ad_out, gpmc_ad_oe
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, gpmc_ad_in,
        input  req_ready, rsp_valid, rsp_rdata, gpmc_clk, gpmc_csn, gpmc_advn,
               gpmc_wein, gpmc_oen, gpmc_ad_out, gpmc_ad_oe
    );

endinterface

// File: rtl/gpmc_sync_master.sv
// Synchronous GPMC initiator: single-beat muxed address/data reads and writes, gpmc_clk = clk/2.
// Latency: accept to rsp_valid is 4+2*WAIT clk; accepts spaced 6+2*WAIT clk.
// req_ready only in IDLE while gpmc_clk is low; one request in flight, no queueing.
module gpmc_sync_master
    import gpmc_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WAIT    = 0,
    parameter int WR_WAIT    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    gpmc_sync_master_if.master  bus
);

    localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = cnt_width(WAIT_MAX);
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

    gpmc_state_t              state_q, state_d;
    logic                     gclk_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     csn_q, csn_d, advn_q, advn_d;
    logic                     wein_q, wein_d, oen_q, oen_d;
    logic                     ad_oe_q, ad_oe_d;
    logic [GPMC_AD_WIDTH-1:0] ad_out_q, ad_out_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     rise;
    logic                     req_ready;

    // The next clk edge sets gpmc_clk, so every bus change lands on a rise edge.
    assign rise      = ~gclk_q;
    assign req_ready = (state_q == ST_IDLE) && ~gclk_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        csn_d       = csn_q;
        advn_d      = advn_q;
        wein_d      = wein_q;
        oen_d       = oen_q;
        ad_oe_d     = ad_oe_q;
        ad_out_d    = ad_out_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready) begin
                    state_d  = ST_ADDR;
                    we_d     = bus.req_we;
                    wdata_d  = DATA_WIDTH'(bus.req_wdata);
                    csn_d    = 1'b0;
                    advn_d   = 1'b0;
                    wein_d   = WEIN_IDLE;
                    oen_d    = OEN_IDLE;
                    ad_oe_d  = 1'b1;
                    ad_out_d = GPMC_AD_WIDTH'(bus.req_addr);
                end
            end
            ST_ADDR: begin
                if (rise) begin
                    state_d = ST_DATA;
                    advn_d  = ADVN_IDLE;
                    if (we_q) begin
                        wein_d   = 1'b0;
                        ad_oe_d  = 1'b1;
                        ad_out_d = GPMC_AD_WIDTH'(wdata_q);
                        cnt_d    = WR_CNT;
                    end else begin
                        oen_d   = 1'b0;
                        ad_oe_d = 1'b0;
                        cnt_d   = RD_CNT;
                    end
                end
            end
            ST_DATA: begin
                if (rise) begin
                    if (cnt_q == '0) begin
                        state_d     = ST_TURN;
                        csn_d       = CSN_IDLE;
                        wein_d      = WEIN_IDLE;
                        oen_d       = OEN_IDLE;
                        ad_oe_d     = AD_OE_IDLE;
                        rsp_valid_d = 1'b1;
                        if (!we_q) rdata_d = DATA_WIDTH'(bus.gpmc_ad_in);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gclk_q      <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            csn_q       <= CSN_IDLE;
            advn_q      <= ADVN_IDLE;
            wein_q      <= WEIN_IDLE;
            oen_q       <= OEN_IDLE;
            ad_oe_q     <= AD_OE_IDLE;
            ad_out_q    <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            gclk_q      <= ~gclk_q;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            csn_q       <= csn_d;
            advn_q      <= advn_d;
            wein_q      <= wein_d;
            oen_q       <= oen_d;
            ad_oe_q     <= ad_oe_d;
            ad_out_q    <= ad_out_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = GPMC_AD_WIDTH'(rdata_q);
    assign bus.gpmc_clk    = gclk_q;
    assign bus.gpmc_csn    = csn_q;
    assign bus.gpmc_advn   = advn_q;
    assign bus.gpmc_wein   = wein_q;
    assign bus.gpmc_oen    = oen_q;
    assign bus.gpmc_ad_out = ad_out_q;
    assign bus.gpmc_ad_oe  = ad_oe_q;

endmodule

// File: tb/tb_gpmc_sync_master.sv
// Bench: two masters (no wait / RD_WAIT=2,WR_WAIT=1) each looped to a behavioural GPMC responder.
module tb_gpmc_sync_master;
    import gpmc_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    gpmc_sync_master_if #(.ADDR_WIDTH(4)) b0 ();
    gpmc_sync_master_if #(.ADDR_WIDTH(4)) b1 ();

    gpmc_sync_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_WAIT(0), .WR_WAIT(0))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.master));
    gpmc_sync_master #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .RD_WAIT(2), .WR_WAIT(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.master));

    logic        sel, t_valid, t_we;
    logic [3:0]  t_addr;
    logic [15:0] t_wdata;
    assign b0.req_valid = t_valid & ~sel;
    assign b1.req_valid = t_valid & sel;
    assign b0.req_we = t_we;     assign b1.req_we = t_we;
    assign b0.req_addr = t_addr; assign b1.req_addr = t_addr;
    assign b0.req_wdata = t_wdata; assign b1.req_wdata = t_wdata;

    // Responders: latch address on the ALE fall, commit writes / drive reads on falls.
    logic [15:0] mem0 [16];
    logic [15:0] mem1 [16];
    logic [3:0]  radr0, radr1;
    logic        rdrv0, rdrv1;
    logic [15:0] rdat0, rdat1;

    always @(negedge b0.gpmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem0[i] <= '0;
            rdrv0 <= 1'b0; radr0 <= '0; rdat0 <= '0;
        end else begin
            if (!b0.gpmc_csn && !b0.gpmc_advn) radr0 <= b0.gpmc_ad_in[3:0];
            if (!b0.gpmc_csn && b0.gpmc_advn && !b0.gpmc_wein) mem0[radr0] <= b0.gpmc_ad_in;
            if (!b0.gpmc_csn && b0.gpmc_advn && !b0.gpmc_oen) begin
                rdrv0 <= 1'b1; rdat0 <= mem0[radr0];
            end else if (b0.gpmc_oen) rdrv0 <= 1'b0;
        end
    end

    always @(negedge b1.gpmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem1[i] <= '0;
            rdrv1 <= 1'b0; radr1 <= '0; rdat1 <= '0;
        end else begin
            if (!b1.gpmc_csn && !b1.gpmc_advn) radr1 <= b1.gpmc_ad_in[3:0];
            if (!b1.gpmc_csn && b1.gpmc_advn && !b1.gpmc_wein) mem1[radr1] <= b1.gpmc_ad_in;
            if (!b1.gpmc_csn && b1.gpmc_advn && !b1.gpmc_oen) begin
                rdrv1 <= 1'b1; rdat1 <= mem1[radr1];
            end else if (b1.gpmc_oen) rdrv1 <= 1'b0;
        end
    end

    assign b0.gpmc_ad_in = b0.gpmc_ad_oe ? b0.gpmc_ad_out :
                           ((rdrv0 && !b0.gpmc_oen) ? rdat0 : 16'hFFFF);
    assign b1.gpmc_ad_in = b1.gpmc_ad_oe ? b1.gpmc_ad_out :
                           ((rdrv1 && !b1.gpmc_oen) ? rdat1 : 16'hFFFF);

    int contend = 0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!b0.gpmc_oen && b0.gpmc_ad_oe) contend++;
            if (!b1.gpmc_oen && b1.gpmc_ad_oe) contend++;
        end
    end

    logic [15:0] rsp_q0 [$];
    int          rsp_cnt0 = 0;
    always @(posedge clk) begin
        #1;
        if (b0.rsp_valid === 1'b1) begin
            rsp_q0.push_back(b0.rsp_rdata);
            rsp_cnt0++;
        end
    end

    logic        o_ready, o_gclk, o_csn, o_advn, o_wein, o_oen, o_ad_oe, o_rv;
    logic [15:0] o_ad_out, o_rd;
    assign o_ready  = sel ? b1.req_ready   : b0.req_ready;
    assign o_gclk   = sel ? b1.gpmc_clk    : b0.gpmc_clk;
    assign o_csn    = sel ? b1.gpmc_csn    : b0.gpmc_csn;
    assign o_advn   = sel ? b1.gpmc_advn   : b0.gpmc_advn;
    assign o_wein   = sel ? b1.gpmc_wein   : b0.gpmc_wein;
    assign o_oen    = sel ? b1.gpmc_oen    : b0.gpmc_oen;
    assign o_ad_oe  = sel ? b1.gpmc_ad_oe  : b0.gpmc_ad_oe;
    assign o_ad_out = sel ? b1.gpmc_ad_out : b0.gpmc_ad_out;
    assign o_rv     = sel ? b1.rsp_valid   : b0.rsp_valid;
    assign o_rd     = sel ? b1.rsp_rdata   : b0.rsp_rdata;

    // Reference memory contents seen through each responder.
    logic [15:0] exp0 [16];
    logic [15:0] exp1 [16];

    logic        tr_csn [16];
    logic        tr_rv  [16];
    logic        tr_oe  [16];
    logic        tr_rdy [16];
    logic [15:0] tr_ad  [16];
    logic [15:0] tr_rd  [16];

    task automatic record(input int k);
        tr_csn[k] = o_csn; tr_rv[k] = o_rv; tr_oe[k] = o_ad_oe;
        tr_rdy[k] = o_ready; tr_ad[k] = o_ad_out; tr_rd[k] = o_rd;
    endtask

    // Issue one request; tr_*[k] holds outputs just after edge Ek (E0 = accept edge).
    task automatic txn(input logic s, input logic we, input logic [3:0] a,
                       input logic [15:0] d, input int n);
        @(negedge clk);
        sel = s; t_we = we; t_addr = a; t_wdata = d; t_valid = 1'b1;
        for (int k = 0; k < 64 && !o_ready; k++) @(negedge clk);
        if (!o_ready) begin
            n_tests++; n_fail++;
            $display("FAIL txn_accept_timeout ready=%0b required=1", o_ready);
            t_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
        record(0);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            record(k);
        end
    endtask

    function automatic int csn_low_count(input int n);
        int c = 0;
        for (int k = 0; k <= n; k++) if (tr_csn[k] === 1'b0) c++;
        return c;
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({o_gclk, b1.gpmc_clk} !== 2'b00) begin
            n_fail++; $display("FAIL reset_gclk got=%b required=00", {o_gclk, b1.gpmc_clk});
        end
        n_tests++;
        if ({o_csn, o_advn, o_wein, o_oen, o_ad_oe} !== 5'b11110) begin
            n_fail++;
            $display("FAIL reset_strobes got=%b required=11110", {o_csn, o_advn, o_wein, o_oen, o_ad_oe});
        end
        n_tests++;
        if ({o_ready, o_rv, o_rd, o_ad_out} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_rsp ready=%b rv=%b rd=%h ad=%h required 1 0 0 0", o_ready, o_rv, o_rd, o_ad_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_tests++;
            if (o_gclk !== ((k % 2) == 0)) begin
                n_fail++; $display("FAIL gclk_toggle edge=%0d got=%b required=%b", k, o_gclk, (k % 2) == 0);
            end
        end
    endtask

    task automatic test_write_read();
        txn(1'b0, 1'b1, 4'd3, 16'hBEEF, 6);
        exp0[3] = 16'hBEEF;
        n_tests++;
        if (csn_low_count(5) != 4 || tr_csn[4] !== 1'b1) begin
            n_fail++; $display("FAIL wr_csn_window low=%0d csn_e4=%b required 4 1", csn_low_count(5), tr_csn[4]);
        end
        n_tests++;
        if (tr_ad[0] !== 16'h0003 || tr_ad[2] !== 16'hBEEF) begin
            n_fail++; $display("FAIL wr_ad_out e0=%h e2=%h required 0003 beef", tr_ad[0], tr_ad[2]);
        end
        n_tests++;
        if ({tr_rv[3], tr_rv[4], tr_rv[5], tr_rdy[5]} !== 4'b0101) begin
            n_fail++; $display("FAIL wr_rsp_timing got=%b required=0101", {tr_rv[3], tr_rv[4], tr_rv[5], tr_rdy[5]});
        end
        txn(1'b0, 1'b0, 4'd3, 16'h0000, 6);
        n_tests++;
        if (tr_rv[4] !== 1'b1 || tr_rd[4] !== exp0[3]) begin
            n_fail++; $display("FAIL rd_beef rv=%b rdata=%h required 1 %h", tr_rv[4], tr_rd[4], exp0[3]);
        end
        n_tests++;
        if (tr_oe[2] !== 1'b0 || csn_low_count(5) != 4) begin
            n_fail++; $display("FAIL rd_bus ad_oe=%b csn_low=%0d required 0 4", tr_oe[2], csn_low_count(5));
        end
    endtask

    task automatic test_back_to_back();
        int acc [32];
        int n = 0;
        int guard = 0;
        rsp_q0.delete();
        @(negedge clk);
        sel = 1'b0; t_we = 1'b1; t_addr = 4'd0; t_wdata = 16'h1000; t_valid = 1'b1;
        while (n < 32 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (o_ready) begin
                @(posedge clk); #1;
                acc[n] = cyc;
                if (n < 16) exp0[n] = 16'h1000 + 16'(n);
                n++;
                if (n < 32) begin
                    t_we = (n < 16); t_addr = 4'(n % 16); t_wdata = 16'h1000 + 16'(n % 16);
                end
            end
        end
        t_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_tests++;
        if (n != 32 || rsp_q0.size() != 32) begin
            n_fail++; $display("FAIL b2b_count accepts=%0d rsps=%0d required 32 32", n, rsp_q0.size());
        end else begin
            for (int i = 1; i < 32; i++) begin
                n_tests++;
                if (acc[i] - acc[i-1] != 6) begin
                    n_fail++; $display("FAIL b2b_spacing idx=%0d got=%0d required=6", i, acc[i] - acc[i-1]);
                end
            end
            for (int i = 0; i < 16; i++) begin
                n_tests++;
                if (rsp_q0[16+i] !== exp0[i]) begin
                    n_fail++; $display("FAIL b2b_rdata addr=%0d got=%h required=%h", i, rsp_q0[16+i], exp0[i]);
                end
            end
        end
    endtask

    task automatic test_rd_wait();
        logic [3:0]  a = 4'($urandom_range(0, 15));
        logic [15:0] d = 16'($urandom);
        txn(1'b1, 1'b1, a, d, 8);
        exp1[a] = d;
        n_tests++;
        if ({tr_rv[5], tr_rv[6]} !== 2'b01 || csn_low_count(7) != 6) begin
            n_fail++; $display("FAIL wrwait_timing rv5_6=%b csn_low=%0d required 01 6", {tr_rv[5], tr_rv[6]}, csn_low_count(7));
        end
        txn(1'b1, 1'b0, a, 16'h0000, 10);
        n_tests++;
        if ({tr_rv[7], tr_rv[8], tr_rv[9]} !== 3'b010) begin
            n_fail++; $display("FAIL rdwait_rsp_edge rv7_9=%b required=010", {tr_rv[7], tr_rv[8], tr_rv[9]});
        end
        n_tests++;
        if (csn_low_count(10) != 8) begin
            n_fail++; $display("FAIL rdwait_csn_low got=%0d required=8", csn_low_count(10));
        end
        n_tests++;
        if (tr_rd[8] !== exp1[a]) begin
            n_fail++; $display("FAIL rdwait_rdata got=%h required=%h", tr_rd[8], exp1[a]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic        we = 1'($urandom_range(0, 1));
            logic [3:0]  a  = 4'($urandom_range(0, 15));
            logic [15:0] d  = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            txn(1'b0, we, a, d, 5);
            n_tests++;
            if (we) begin
                exp0[a] = d;
                if (tr_rv[4] !== 1'b1) begin
                    n_fail++; $display("FAIL rand_wr i=%0d rv=%b required=1", i, tr_rv[4]);
                end
            end else if (tr_rv[4] !== 1'b1 || tr_rd[4] !== exp0[a]) begin
                n_fail++; $display("FAIL rand_rd i=%0d addr=%0d rv=%b got=%h required=%h", i, a, tr_rv[4], tr_rd[4], exp0[a]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int rc;
        @(negedge clk);
        sel = 1'b0; t_we = 1'b1; t_addr = 4'd9; t_wdata = 16'($urandom); t_valid = 1'b1;
        for (int k = 0; k < 64 && !o_ready; k++) @(negedge clk);
        @(posedge clk); #1;
        t_valid = 1'b0;
        rc = rsp_cnt0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_csn, o_advn, o_wein, o_oen, o_ad_oe, o_gclk} !== 6'b111100) begin
            n_fail++;
            $display("FAIL midrst_strobes got=%b required=111100", {o_csn, o_advn, o_wein, o_oen, o_ad_oe, o_gclk});
        end
        repeat (4) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin exp0[i] = '0; exp1[i] = '0; end
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (rsp_cnt0 != rc) begin
            n_fail++; $display("FAIL midrst_no_rsp got=%0d required=%0d", rsp_cnt0, rc);
        end
        txn(1'b0, 1'b1, 4'd5, 16'h1234, 5);
        exp0[5] = 16'h1234;
        txn(1'b0, 1'b0, 4'd5, 16'h0000, 5);
        n_tests++;
        if (tr_rv[4] !== 1'b1 || tr_rd[4] !== exp0[5]) begin
            n_fail++; $display("FAIL midrst_recover rv=%b got=%h required 1 %h", tr_rv[4], tr_rd[4], exp0[5]);
        end
    endtask

    task automatic test_valid_phase();
        logic [15:0] d = 16'($urandom);
        sel = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        if (o_gclk !== 1'b1) @(negedge clk);
        t_we = 1'b1; t_addr = 4'd2; t_wdata = d; t_valid = 1'b1;
        n_tests++;
        if (o_ready !== 1'b0) begin
            n_fail++; $display("FAIL phase_ready gclk=%b ready=%b required 0", o_gclk, o_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (o_csn !== 1'b1) begin
            n_fail++; $display("FAIL phase_no_accept csn=%b required=1", o_csn);
        end
        @(posedge clk); #1;
        t_valid = 1'b0;
        n_tests++;
        if (o_csn !== 1'b0 || o_ad_out !== 16'h0002) begin
            n_fail++; $display("FAIL phase_accept csn=%b ad=%h required 0 0002", o_csn, o_ad_out);
        end
        exp0[2] = d;
        repeat (6) @(posedge clk);
        txn(1'b0, 1'b0, 4'd2, 16'h0000, 5);
        n_tests++;
        if (tr_rd[4] !== exp0[2]) begin
            n_fail++; $display("FAIL phase_rdata got=%h required=%h", tr_rd[4], exp0[2]);
        end
    endtask

    task automatic test_contention();
        n_tests++;
        if (contend != 0) begin
            n_fail++; $display("FAIL ad_contention cycles=%0d required=0", contend);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0; t_valid = 1'b0; t_we = 1'b0; t_addr = '0; t_wdata = '0;
        for (int i = 0; i < 16; i++) begin exp0[i] = '0; exp1[i] = '0; end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_rd_wait();
        test_random();
        test_mid_reset();
        test_valid_phase();
        test_contention();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout time=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpmc_sync_master.md
# gpmc_sync_master

Synchronous GPMC initiator: it generates `gpmc_clk` and drives single-beat multiplexed address/data reads and writes onto a 16-bit GPMC bus. It is the host end of the same bus that the FPGA-side GPMC responder serves. It sits between an internal valid/ready request port and the GPMC pads, and is used as the bus master in loopback benches and in designs where the FPGA hosts a GPMC peripheral. Each access takes a fixed number of GPMC cycles, set by parameters.

## Interface
- `ADDR_WIDTH`, 4: request address width; zero-extended onto the 16-bit AD bus during the address phase.
- `DATA_WIDTH`, 16: data width; must equal 16.
- `RD_WAIT`, 0: extra GPMC cycles added to the read data phase.
- `WR_WAIT`, 0: extra GPMC cycles added to the write data phase.

Ports:
- `clk` in 1: system clock; `gpmc_clk` runs at `clk`/2.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a `clk` edge where `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_WIDTH`: access address.
- `req_wdata` in 16: write data.
- `rsp_valid` out 1: one-`clk` completion pulse, for both reads and writes.
- `rsp_rdata` out 16: read data; holds its value until the next read completes.
- `gpmc_clk` out 1: bus clock.
- `gpmc_csn`, `gpmc_advn`, `gpmc_wein`, `gpmc_oen` out 1 each: active-low bus strobes.
- `gpmc_ad_out` out 16: AD drive value.
- `gpmc_ad_oe` out 1: AD output enable.
- `gpmc_ad_in` in 16: AD pad input.

## Operation
- `gpmc_clk` is a register that toggles on every `clk` edge while `rst_n` is high. A "rise edge" is a `clk` edge that sets `gpmc_clk` to 1.
- All bus outputs change only on rise edges. The responder samples on `gpmc_clk` falling edges.
- States and transitions:
  - IDLE → ADDR on accept.
  - ADDR → DATA.
  - DATA → TURN after 1+WAIT GPMC cycles.
  - TURN → IDLE.
- `req_ready = (state==IDLE) && !gpmc_clk`. The accept edge is therefore always a rise edge.
- Request fields are captured on accept.
- ADDR state: `csn`=0, `advn`=0, `wein`=1, `oen`=1, `ad_oe`=1, `ad_out`={zeros, addr}.
- Write DATA state: `advn`=1, `wein`=0, `ad_oe`=1, `ad_out`=wdata.
- Read DATA state: `advn`=1, `oen`=0, `ad_oe`=0.
- Entering TURN, all of the following happen on the same rise edge:
  - `csn`=1, `wein`=1, `oen`=1, `ad_oe`=0.
  - `rsp_valid`=1 for one `clk`.
  - On reads, `gpmc_ad_in` (pre-edge value) is captured into `rsp_rdata`.
- Reset values: `gpmc_clk`=0, `csn`/`advn`/`wein`/`oen`=1, `ad_oe`=0, `ad_out`=0, `rsp_valid`=0, `rsp_rdata`=0, state IDLE. `req_ready`=1 while in reset.
- Reset mid-transaction: outputs return to their idle values asynchronously and no `rsp_valid` is issued. The in-flight request is dropped.
- `req_valid` while `req_ready`=0 is ignored. The requester must hold it.

## Timing
- Label the accept edge E0. Each GPMC cycle is 2 `clk`.
- Address phase: E0 to E2. The responder latches the address at E1.
- Data phase: E2 to E(4+2·WAIT).
  - Write: data is committed at E3+2·WR_WAIT.
  - Read: the responder registers data at E3 and drives it from E3.
- Completion edge: `rsp_valid` is asserted at E(4+2·WAIT) and `csn` rises on the same edge.
- TURN is one `clk`. `req_ready` is high again at E(5+2·WAIT).
- Back-to-back accepts are spaced (6+2·WAIT) `clk` apart.
- `csn` is low for exactly 2+WAIT GPMC cycles.
- The AD bus is never driven by the master while `oen`=0.

## Structure
- Shared package `gpmc_pkg`:
  - State encoding (IDLE, ADDR, DATA, TURN).
  - `GPMC_AD_WIDTH`=16.
  - Strobe idle constants.
- Optional sub-module `gpmc_ad_pad`: 16 bidirectional pad cells (ICE40 `SB_IO`) joining `ad_out`/`ad_oe`/`ad_in` to an `inout [15:0]`. The core stays pad-free for simulation.
- Core: a single wait counter sized to max(RD_WAIT, WR_WAIT)+1.

## Test plan
Bench: the master connected to the existing GPMC responder (ADDR_WIDTH=4) through a pad model.
1. Reset: hold `rst_n`=0 → `gpmc_clk`=0, all strobes 1, `ad_oe`=0, `req_ready`=1. Release → `gpmc_clk` toggles every `clk`.
2. Write addr 3 / 0xBEEF, then read addr 3:
   - `csn` low at E0..E4.
   - `ad_out`=0x0003 at E0, 0xBEEF at E2.
   - Read `rsp_valid` at E4 with `rsp_rdata`=0xBEEF.
3. `req_valid` held high: write 0x1000+i to addresses 0..15, then read them all back:
   - Accepts every 6 `clk`.
   - All 16 values match.
4. RD_WAIT=2: read → `rsp_valid` at E8, `csn` low for 8 `clk`, data correct.
5. Assert `rst_n`=0 at E3 of a write:
   - Strobes return to 1 immediately.
   - No `rsp_valid`.
   - After release, a write/read of addr 5 / 0x1234 returns 0x1234.
6. Raise `req_valid` on a `clk` where `gpmc_clk`=1 → no accept on that edge; accept on the following edge.
